// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory port arbiter.
// Owner encoding plus hold counter sizing helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

  localparam int MAX_HOLD_DEF = 8;

  function automatic int hold_w(int max_hold);
    return (max_hold > 1) ? $clog2(max_hold) : 1;
  endfunction

  localparam int HOLD_W = hold_w(MAX_HOLD_DEF);

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side bundle of the shared memory port.
// master = requester, slave = arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] adr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              stall;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, adr, wdata,
    input  gnt, stall, rdata
  );

  modport slave (
    input  req, we, adr, wdata,
    output gnt, stall, rdata
  );
endinterface

// File: rtl/mux2.sv
// Generic two-input mux, sel=1 picks d1.
// Shared datapath building block.
module mux2 #(
  parameter int W = 32
) (
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic         sel,
  output logic [W-1:0] y
);
  assign y = sel ? d1 : d0;
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between CPU and DMA,
// with a bounded hold so a waiting requester is never starved.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 8
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave cpu,
  mem_port_arbiter_if.slave dma,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wd,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rd
);

  localparam int CW = hold_w(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD - 1);

  owner_e          owner, owner_nx;
  owner_e          last, last_nx;
  owner_e          other;
  logic [CW-1:0]   hold_cnt, hold_nx;
  logic            own_req, own_we, oth_req;
  logic            access;
  logic [ADDR_W-1:0] adr_sel;
  logic [DATA_W-1:0] wd_sel;

  assign cpu.gnt = (owner == OWN_CPU);
  assign dma.gnt = (owner == OWN_DMA);

  always_comb begin
    own_req = 1'b0;
    own_we  = 1'b0;
    oth_req = 1'b0;
    other   = OWN_NONE;
    unique case (1'b1)
      cpu.gnt: begin
        own_req = cpu.req;
        own_we  = cpu.we;
        oth_req = dma.req;
        other   = OWN_DMA;
      end
      dma.gnt: begin
        own_req = dma.req;
        own_we  = dma.we;
        oth_req = cpu.req;
        other   = OWN_CPU;
      end
      default: ;
    endcase
  end

  assign access = own_req;

  always_comb begin
    owner_nx = owner;
    hold_nx  = hold_cnt;
    last_nx  = last;
    if (owner == OWN_NONE) begin
      if (cpu.req && dma.req)
        owner_nx = (last == OWN_CPU) ? OWN_DMA : OWN_CPU;
      else if (cpu.req)
        owner_nx = OWN_CPU;
      else if (dma.req)
        owner_nx = OWN_DMA;
    end else if (!own_req) begin
      owner_nx = oth_req ? other : OWN_NONE;
    end else if (oth_req && hold_cnt == HOLD_MAX) begin
      owner_nx = other;
    end
    if (owner_nx != owner)
      hold_nx = '0;
    else if (access && hold_cnt != HOLD_MAX)
      hold_nx = hold_cnt + 1'b1;
    if (owner_nx != OWN_NONE)
      last_nx = owner_nx;
  end

  // last resets to DMA so the CPU wins the first tie
  always_ff @(posedge clk) begin
    if (reset) begin
      owner    <= OWN_NONE;
      last     <= OWN_DMA;
      hold_cnt <= '0;
    end else begin
      owner    <= owner_nx;
      last     <= last_nx;
      hold_cnt <= hold_nx;
    end
  end

  mux2 #(.W(ADDR_W)) u_adr_mux (
    .d0  (cpu.adr),
    .d1  (dma.adr),
    .sel (dma.gnt),
    .y   (adr_sel)
  );

  mux2 #(.W(DATA_W)) u_wd_mux (
    .d0  (cpu.wdata),
    .d1  (dma.wdata),
    .sel (dma.gnt),
    .y   (wd_sel)
  );

  assign mem_adr = access ? adr_sel : '0;
  assign mem_wd  = access ? wd_sel  : '0;
  assign mem_we  = access & own_we & ~reset;

  assign cpu.stall = cpu.req & ~cpu.gnt & ~reset;
  assign dma.stall = dma.req & ~dma.gnt & ~reset;

  assign cpu.rdata = mem_rd;
  assign dma.rdata = mem_rd;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic
// checked every cycle against a rule-level ownership model.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MH = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wd;
  logic          mem_we;
  logic [DW-1:0] mem_rd;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) cpu_if ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) dma_if ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
    .clk     (clk),
    .reset   (reset),
    .cpu     (cpu_if),
    .dma     (dma_if),
    .mem_adr (mem_adr),
    .mem_wd  (mem_wd),
    .mem_we  (mem_we),
    .mem_rd  (mem_rd)
  );

  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];

  assign mem_rd = mem[mem_adr[9:2]];

  always @(posedge clk)
    if (mem_we) mem[mem_adr[9:2]] <= mem_wd;

  int errors = 0;
  int checks = 0;

  // model: 0 = nobody, 1 = cpu, 2 = dma
  int own = 0;
  int lst = 2;
  int streak = 0;
  int last_acc = 0;
  int wt [1:2];

  function automatic logic rq(int i);
    return (i == 1) ? cpu_if.req : dma_if.req;
  endfunction
  function automatic logic wev(int i);
    return (i == 1) ? cpu_if.we : dma_if.we;
  endfunction
  function automatic logic [31:0] ad(int i);
    return (i == 1) ? cpu_if.adr : dma_if.adr;
  endfunction
  function automatic logic [31:0] wdv(int i);
    return (i == 1) ? cpu_if.wdata : dma_if.wdata;
  endfunction
  function automatic logic gv(int i);
    return (i == 1) ? cpu_if.gnt : dma_if.gnt;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(int i, logic r, logic w,
                       logic [31:0] a, logic [31:0] d);
    if (i == 1) begin
      cpu_if.req = r; cpu_if.we = w;
      cpu_if.adr = a; cpu_if.wdata = d;
    end else begin
      dma_if.req = r; dma_if.we = w;
      dma_if.adr = a; dma_if.wdata = d;
    end
  endtask

  task automatic sample();
    logic        acc;
    logic [31:0] ea, ed;
    @(negedge clk);
    acc = (own != 0) && rq(own);
    ea  = acc ? ad(own) : 32'h0;
    ed  = acc ? wdv(own) : 32'h0;
    check("cpu_gnt", cpu_if.gnt, 32'(own == 1));
    check("dma_gnt", dma_if.gnt, 32'(own == 2));
    check("cpu_stall", cpu_if.stall,
          32'(cpu_if.req && own != 1 && !reset));
    check("mem_adr", mem_adr, ea);
    check("mem_wd", mem_wd, ed);
    check("mem_we", mem_we, 32'(acc && wev(own) && !reset));
    check("rdata", cpu_if.rdata, ref_mem[ea[9:2]]);
    for (int i = 1; i <= 2; i++) begin
      if (reset || !rq(i)) wt[i] = 0;
      else if (gv(i)) begin
        if (wt[i] > 0) check("wait_bound", 32'(wt[i] <= MH + 1), 32'd1);
        wt[i] = 0;
      end else wt[i]++;
    end
  endtask

  task automatic advance();
    logic        acc;
    int          nx, oth;
    logic [31:0] a;
    @(posedge clk);
    if (reset) begin
      own = 0; lst = 2; streak = 0; last_acc = 0;
    end else begin
      acc = (own != 0) && rq(own);
      last_acc = acc ? own : 0;
      if (acc && wev(own)) begin
        a = ad(own);
        ref_mem[a[9:2]] = wdv(own);
      end
      nx = own;
      if (own == 0) begin
        if (rq(1) && rq(2)) nx = 3 - lst;
        else if (rq(1)) nx = 1;
        else if (rq(2)) nx = 2;
      end else begin
        oth = 3 - own;
        if (!rq(own)) nx = rq(oth) ? oth : 0;
        else if (rq(oth) && streak >= MH - 1) nx = oth;
      end
      if (nx != own) streak = 0;
      else if (acc && streak < MH - 1) streak++;
      if (nx != 0) lst = nx;
      own = nx;
    end
    #1;
  endtask

  task automatic cyc();
    sample();
    advance();
  endtask

  task automatic idle_reset();
    drive(1, 0, 0, 0, 0);
    drive(2, 0, 0, 0, 0);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  task automatic new_txn(int i);
    drive(i, 1'b1, 1'($urandom_range(0, 1)),
          {22'h0, 8'($urandom_range(0, 255)), 2'b00}, $urandom);
  endtask

  initial begin
    int          nacc, nst, dadr;
    logic        got, a;

    wt[1] = 0; wt[2] = 0;
    for (int k = 0; k < 256; k++) begin
      mem[k]     = 32'hA500_0000 ^ (k * 32'h0001_0203);
      ref_mem[k] = mem[k];
    end
    mem[16] = 32'hDEAD_BEEF;
    ref_mem[16] = 32'hDEAD_BEEF;

    reset = 1'b1;
    drive(1, 0, 0, 0, 0);
    drive(2, 0, 0, 0, 0);
    advance();
    cyc();
    reset = 1'b0;

    // reset then CPU read
    drive(1, 1, 0, 32'h40, 0);
    sample();
    check("t1_stall", cpu_if.stall, 1);
    check("t1_nogrant", cpu_if.gnt, 0);
    advance();
    sample();
    check("t1_gnt", cpu_if.gnt, 1);
    check("t1_adr", mem_adr, 32'h40);
    check("t1_rdata", cpu_if.rdata, 32'hDEAD_BEEF);
    check("t1_we", mem_we, 0);
    advance();
    drive(1, 0, 0, 0, 0);
    cyc();

    // tie at idle
    idle_reset();
    drive(1, 1, 0, 32'h20, 0);
    drive(2, 1, 0, 32'h24, 0);
    cyc();
    sample();
    check("t2_cpu_first", cpu_if.gnt, 1);
    check("t2_dma_wait", dma_if.gnt, 0);
    advance();
    drive(1, 0, 0, 0, 0);
    cyc();
    sample();
    check("t2_handover", dma_if.gnt, 1);
    advance();
    drive(2, 0, 0, 0, 0);
    cyc();
    cyc();

    // hold limit
    idle_reset();
    dadr = 32'h100;
    drive(2, 1, 1, dadr, $urandom);
    nacc = 0; nst = 0; got = 0;
    for (int k = 0; k < 30; k++) begin
      if (k == 2) drive(1, 1, 0, 32'h44, 0);
      sample();
      if (cpu_if.gnt) got = 1;
      else begin
        if (dma_if.gnt && dma_if.req) nacc++;
        if (cpu_if.stall) nst++;
      end
      a = dma_if.gnt && dma_if.req;
      advance();
      if (got) break;
      if (a) begin
        dadr += 4;
        drive(2, 1, 1, dadr, $urandom);
      end
    end
    check("t3_granted", 32'(got), 1);
    check("t3_dma_burst", nacc, 8);
    check("t3_stall_len", nst, 7);
    check("t3_stall_bound", 32'(nst <= MH + 1), 1);
    drive(1, 0, 0, 0, 0);
    drive(2, 0, 0, 0, 0);
    cyc();
    cyc();

    // write gating
    idle_reset();
    drive(2, 1, 1, 32'h200, 32'h1234_5678);
    sample();
    check("t4_we_idle", mem_we, 0);
    advance();
    sample();
    check("t4_gnt", dma_if.gnt, 1);
    check("t4_we", mem_we, 1);
    check("t4_wd", mem_wd, 32'h1234_5678);
    check("t4_adr", mem_adr, 32'h200);
    advance();
    drive(2, 0, 0, 0, 0);
    drive(1, 1, 0, 32'h200, 0);
    sample();
    check("t4_we_bubble", mem_we, 0);
    advance();
    sample();
    check("t4_cpu_gnt", cpu_if.gnt, 1);
    check("t4_cpu_we", mem_we, 0);
    check("t4_readback", cpu_if.rdata, 32'h1234_5678);
    advance();
    drive(1, 0, 0, 0, 0);
    cyc();
    cyc();

    // reset mid-operation
    idle_reset();
    drive(2, 1, 1, 32'h240, 32'hCAFE_F00D);
    cyc();
    reset = 1'b1;
    drive(1, 1, 0, 32'h240, 0);
    sample();
    check("t5_owner_dma", dma_if.gnt, 1);
    check("t5_we_killed", mem_we, 0);
    advance();
    reset = 1'b0;
    sample();
    check("t5_cpu_gnt0", cpu_if.gnt, 0);
    check("t5_dma_gnt0", dma_if.gnt, 0);
    advance();
    sample();
    check("t5_tie_cpu", cpu_if.gnt, 1);
    check("t5_no_commit", 32'(cpu_if.rdata == 32'hCAFE_F00D), 0);
    advance();
    drive(1, 0, 0, 0, 0);
    drive(2, 0, 0, 0, 0);
    cyc();
    cyc();

    // early request drop
    idle_reset();
    drive(1, 1, 0, 32'h80, 0);
    repeat (10) cyc();
    drive(2, 1, 1, 32'h300, 32'h55AA_55AA);
    sample();
    check("t6_cpu_holds", cpu_if.gnt, 1);
    advance();
    drive(2, 0, 1, 32'h300, 32'h55AA_55AA);
    sample();
    check("t6_dma_gnt", dma_if.gnt, 1);
    check("t6_we", mem_we, 0);
    check("t6_adr", mem_adr, 0);
    advance();
    sample();
    check("t6_back_cpu", cpu_if.gnt, 1);
    advance();
    drive(1, 0, 0, 0, 0);
    drive(2, 0, 0, 0, 0);
    cyc();
    cyc();

    // random traffic
    repeat (3000) begin
      for (int i = 1; i <= 2; i++) begin
        if (rq(i)) begin
          if (last_acc == i) begin
            if ($urandom_range(0, 9) < 8) new_txn(i);
            else drive(i, 0, 0, 0, 0);
          end else if ($urandom_range(0, 19) == 0) begin
            drive(i, 0, 0, 0, 0);
          end
        end else if ($urandom_range(0, 9) < 4) begin
          new_txn(i);
        end
      end
      reset = ($urandom_range(0, 99) == 0);
      cyc();
    end
    reset = 1'b0;
    drive(1, 0, 0, 0, 0);
    drive(2, 0, 0, 0, 0);
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
